sevenseg_scan: RTL and testbench
================================

Name: sevenseg_scan

Overview:
- Time-multiplexed display controller. One internal `sevenseg` decoder is shared across DIGITS common-anode digits.
- Cycles a digit index at a fixed refresh rate and drives the shared decoder with the selected BCD nibble.
- Drives active-low anode enables, with anti-ghosting blanking and leading-zero suppression.
- New display values are double-buffered and take effect only at frame boundaries, so no tearing occurs.

Parameters:
- DIGITS, 4: number of digits, legal range 1..8.
- PRESCALE, 50000: clock cycles per digit slot. Must be >= 2.
- GHOST, 500: cycles at the start of each slot during which all anodes are off. Must be < PRESCALE.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  scan enable; low freezes the scan and blanks the display.
- data_in  input  4*DIGITS  BCD digits; nibble k is digit k, and digit 0 is least significant.
- load  input  1  single-cycle strobe that captures data_in into the pending buffer.
- lz_blank  input  1  1 enables leading-zero suppression.
- seg_out  output  7  decoded segments {G,F,E,D,C,B,A}, active-high, registered.
- anode_out  output  DIGITS  anode enables, active-low, one-hot-low or all ones, registered.
- pending  output  1  1 while a loaded value is waiting for a frame boundary.
- frame_done  output  1  one-cycle pulse after each completed frame.

Behaviour:
- State registers:
  - cnt: 0..PRESCALE-1
  - idx: 0..DIGITS-1
  - active[4*DIGITS]
  - pend_data[4*DIGITS]
  - pend_valid
- Reset (synchronous, overrides everything, including mid-frame):
  - cnt=0, idx=0, active=0, pend_data=0, pend_valid=0.
  - seg_out=7'b0, anode_out=all ones, pending=0, frame_done=0.
- Scan, when en=1:
  - cnt increments each cycle.
  - At cnt=PRESCALE-1, cnt wraps to 0 and idx advances, wrapping from DIGITS-1 to 0.
  - When en=0, cnt and idx hold, anode_out is forced to all ones next cycle, and frame_done stays 0.
- Frame boundary is the cycle where en=1, cnt=PRESCALE-1 and idx=DIGITS-1. On that edge:
  - frame_done goes high for exactly one cycle.
  - If pend_valid=1, then active<=pend_data and pend_valid<=0.
- Load:
  - load=1 sets pend_data<=data_in and pend_valid<=1. This works in any cycle, including while en=0.
  - Loading while pend_valid=1 overwrites pend_data; the latest load wins.
  - Load in the same cycle as a boundary: active takes the old pend_data if it was valid. pend_data takes data_in and pend_valid stays 1, so the new value lands at the next boundary.
  - pending equals pend_valid.
- Outputs are registered and computed from the current cnt, idx and active, so they lag the state by one cycle:
  - seg_out <= sevenseg(active[4*idx+:4]). Non-BCD nibbles (>9) decode to all-off, as the decoder does.
  - anode_out <= all ones if en=0, or cnt<GHOST, or digit idx is suppressed.
  - Otherwise anode_out <= ~(1<<idx).
- Leading-zero suppression:
  - With lz_blank=1, digit k (k>=1) is suppressed when active digits k..DIGITS-1 are all 0.
  - Digit 0 is never suppressed, so the value 0 shows a single "0".
  - With lz_blank=0, no digit is suppressed.
  - lz_blank is sampled live; no buffering.
- Invariants:
  - At most one anode_out bit is low.
  - No anode is ever low during the first GHOST cycles of a slot.

Test Plan:
Bench parameters DIGITS=4, PRESCALE=4, GHOST=1.
- Reset then en=1, no load:
  - seg_out=7'b0111111 ("0" on all digits via active=0).
  - With lz_blank=1 only anode 0 ever goes low: anode_out=4'b1110 for 3 of every 4 cycles in slot 0, else 4'b1111.
  - frame_done pulses every 16 cycles.
- load data_in=16'h1234 mid-frame:
  - pending=1 until the boundary, then 0.
  - Display unchanged until frame_done.
  - Next frame shows slot0 seg=7'b1100110 ("4") with anode 4'b1110, slot3 seg=7'b0000110 ("1") with anode 4'b0111.
- Two loads (16'h0005 then 16'h0042) before one boundary:
  - Next frame shows 0042.
  - With lz_blank=1, digits 2 and 3 keep anode high; with lz_blank=0, all four digits are lit.
- load asserted exactly on the boundary cycle with pending 16'h0011 already queued:
  - Frame N+1 shows 0011.
  - The new value shows at frame N+2.
  - pending stays 1 across the boundary.
- en dropped mid-slot for 10 cycles:
  - anode_out=4'b1111 throughout; cnt and idx frozen.
  - Scan resumes at the same cnt and idx; no frame_done while disabled.
- reset asserted mid-frame with pending=1:
  - Next cycle all outputs are at reset values and pending=0.
  - Display returns to "0".
- load data_in=16'h00A0 with lz_blank=1:
  - Digit 1 seg=7'b0000000 (invalid BCD) but anode still low, since A is treated as nonzero.
  - Digits 2 and 3 are suppressed.

Source files
------------

// File: rtl/sevenseg_scan.sv
// sevenseg_scan
//   Time-multiplexed seven-segment display controller. A single BCD decoder
//   is shared across DIGITS common-anode digits. A slot counter (cnt) and a
//   digit index (idx) scan the digits. New values are double-buffered and
//   only become visible at a frame boundary, so a half-old, half-new frame
//   is never displayed.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   en         scan enable; low freezes cnt/idx and blanks all anodes
//   data_in    4*DIGITS BCD digits, nibble 0 is least significant
//   load       one-cycle strobe capturing data_in into the pending buffer
//   lz_blank   enables leading-zero suppression (sampled live)
//   seg_out    registered segments {G,F,E,D,C,B,A}, active-high
//   anode_out  registered anode enables, active-low, at most one low
//   pending    high while a loaded value waits for a frame boundary
//   frame_done one-cycle pulse after each completed frame
module sevenseg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GHOST    = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  input  logic                  lz_blank,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     anode_out,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GHOST_CNT = CNT_W'(GHOST);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] pend_data;
  logic                pend_valid;

  logic                boundary;
  logic [DIGITS-1:0]   suppressed;
  logic [3:0]          cur_digit;
  logic [DIGITS-1:0]   cur_anode;

  // Shared BCD decoder; codes above 9 light nothing.
  function automatic logic [6:0] sevenseg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign boundary = en && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign pending  = pend_valid;

  // Digit k is suppressed when it and every more significant digit are zero.
  // Scanning from the top keeps a running "all zero so far" flag; digit 0 is
  // never suppressed so a zero value still shows one "0".
  always_comb begin : lz_logic
    logic zero_above;
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    zero_above = 1'b1;
    suppressed = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above && (active[4*k +: 4] == 4'd0);
      suppressed[k] = lz_blank && zero_above;
    end
  end

  always_comb begin
    cur_digit = active[4*idx +: 4];
    cur_anode = '1;
    // The ghost window blanks every anode at the start of a slot so the
    // previous digit's segments never flash on the next anode.
    if (en && (cnt >= GHOST_CNT) && !suppressed[idx]) begin
      cur_anode = ~(DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      seg_out    <= 7'b0;
      anode_out  <= '1;
      frame_done <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // right-hand side below sees the pre-edge values of cnt, idx, active.
      if (en) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // A load on a boundary edge still lets the older pending value land
      // now; the new value stays pending for the following boundary.
      if (boundary && pend_valid) begin
        active <= pend_data;
      end

      if (load) begin
        pend_data  <= data_in;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end

      seg_out    <= sevenseg(cur_digit);
      anode_out  <= cur_anode;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
//   Scoreboard bench for sevenseg_scan with DIGITS=4, PRESCALE=4, GHOST=1.
//   The stimulus process pushes the hand-computed contents of an upcoming
//   frame into a queue; the monitor pops one entry on each frame_done pulse
//   and compares the following 16 output cycles against it.
module tb_sevenseg_scan;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int GHOST    = 1;
  localparam int FRAME    = DIGITS * PRESCALE;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S7 = 7'b0000111;
  localparam logic [6:0] SX = 7'b0000000;

  localparam logic [3:0] OFF = 4'b1111;

  typedef struct packed {
    int          id;
    logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
    logic [15:0] an;    // anode pattern while each slot is lit
  } frame_t;

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic [4*DIGITS-1:0]   data_in;
  logic                  load;
  logic                  lz_blank;
  logic [6:0]            seg_out;
  logic [DIGITS-1:0]     anode_out;
  logic                  pending;
  logic                  frame_done;

  frame_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  sevenseg_scan #(
    .DIGITS  (DIGITS),
    .PRESCALE(PRESCALE),
    .GHOST   (GHOST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .data_in   (data_in),
    .load      (load),
    .lz_blank  (lz_blank),
    .seg_out   (seg_out),
    .anode_out (anode_out),
    .pending   (pending),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int id, input logic [27:0] seg, input logic [15:0] an);
    frame_t f;
    f.id  = id;
    f.seg = seg;
    f.an  = an;
    exp_q.push_back(f);
  endtask

  // Returns on the negedge where frame_done is seen high.
  task automatic wait_frame_done(input string name);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: on frame_done, start checking the next FRAME samples against
  // the oldest queued frame (if any).
  initial begin : monitor
    frame_t cur;
    int     pos;
    int     slot;
    logic [3:0] exp_an;
    pos = -1;
    forever begin
      @(negedge clk);
      if (pos >= 0) begin
        slot   = pos / PRESCALE;
        exp_an = (pos % PRESCALE < GHOST) ? OFF : cur.an[slot*4 +: 4];
        check($sformatf("f%0d_p%0d_seg", cur.id, pos), 32'(seg_out), 32'(cur.seg[slot*7 +: 7]));
        check($sformatf("f%0d_p%0d_an", cur.id, pos), 32'(anode_out), 32'(exp_an));
        check($sformatf("f%0d_p%0d_fd", cur.id, pos), 32'(frame_done), 32'(pos == FRAME - 1));
        pos++;
        if (pos == FRAME) pos = -1;
      end
      if (frame_done && pos < 0 && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        pos = 0;
      end
    end
  end

  // Anode pattern after resuming from the en=0 freeze at cnt=1, idx=1.
  logic [3:0] resume_an [0:10];

  initial begin : stimulus
    resume_an = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1011, 4'b1011,
                  4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111};
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    lz_blank = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_out), 32'd0);
    check("rst_an", 32'(anode_out), 32'(OFF));
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);

    // Zeros with suppression: only digit 0 lights.
    reset = 1'b0;
    en    = 1'b1;
    push_frame(0, {S0, S0, S0, S0}, {OFF, OFF, OFF, 4'b1110});
    wait_frame_done("f1");

    // Mid-frame load: the frame in progress keeps showing zeros.
    repeat (5) @(negedge clk);
    data_in = 16'h1234;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("load1234_pending", 32'(pending), 32'd1);
    push_frame(1, {S1, S2, S3, S4}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
    wait_frame_done("f2");
    check("load1234_pending_clr", 32'(pending), 32'd0);

    // Two loads before one boundary: the latest one wins.
    repeat (2) @(negedge clk);
    data_in = 16'h0005;
    load    = 1'b1;
    @(negedge clk);
    data_in = 16'h0042;
    @(negedge clk);
    load = 1'b0;
    push_frame(2, {S0, S0, S4, S2}, {OFF, OFF, 4'b1101, 4'b1110});
    push_frame(3, {S0, S0, S4, S2}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
    wait_frame_done("f3");
    wait_frame_done("f4");
    lz_blank = 1'b0;

    // Queue 0011, then load 0077 on the boundary cycle itself.
    repeat (3) @(negedge clk);
    data_in = 16'h0011;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame(4, {S0, S0, S1, S1}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
    repeat (11) @(negedge clk);
    data_in = 16'h0077;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("bnd_load_fd", 32'(frame_done), 32'd1);
    check("bnd_load_pending", 32'(pending), 32'd1);
    repeat (4) @(negedge clk);
    push_frame(5, {S0, S0, S7, S7}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
    wait_frame_done("f6");
    check("bnd_load_pending_clr", 32'(pending), 32'd0);

    // Freeze the scan for 10 cycles at cnt=1, idx=1.
    wait_frame_done("f7");
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("dis%0d_an", i), 32'(anode_out), 32'(OFF));
      check($sformatf("dis%0d_fd", i), 32'(frame_done), 32'd0);
      check($sformatf("dis%0d_seg", i), 32'(seg_out), 32'(S7));
    end
    en = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      check($sformatf("resume%0d_an", j), 32'(anode_out), 32'(resume_an[j]));
      check($sformatf("resume%0d_fd", j), 32'(frame_done), 32'(j == 10));
    end

    // Reset mid-frame with a value pending.
    repeat (3) @(negedge clk);
    data_in = 16'h0099;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("pre_rst_pending", 32'(pending), 32'd1);
    reset    = 1'b1;
    lz_blank = 1'b1;
    @(negedge clk);
    check("mid_rst_seg", 32'(seg_out), 32'd0);
    check("mid_rst_an", 32'(anode_out), 32'(OFF));
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;
    push_frame(6, {S0, S0, S0, S0}, {OFF, OFF, OFF, 4'b1110});
    wait_frame_done("f_post_rst");

    // Non-BCD digit counts as nonzero for suppression but decodes blank.
    repeat (4) @(negedge clk);
    data_in = 16'h00A0;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    push_frame(7, {S0, S0, SX, S0}, {OFF, OFF, 4'b1101, 4'b1110});
    wait_frame_done("f_a0_start");
    wait_frame_done("f_a0_end");
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
